// File: rtl/user_input_reader_pkg.sv
// Shared constants and address decode for the user input reader (DIP switches + push keys).
package user_input_reader_pkg;

  localparam logic [31:0] ADDR_DIP_LO = 32'h0000_7f2c;
  localparam logic [31:0] ADDR_DIP_HI = 32'h0000_7f30;
  localparam logic [31:0] ADDR_KEY    = 32'h0000_7f34;
  localparam logic [31:0] ADDR_END    = 32'h0000_7f38;

  localparam logic [31:0] DEB_CNT_DEF = 32'd15000;
  localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RSEL_DIP_LO,
    RSEL_DIP_HI,
    RSEL_KEY,
    RSEL_NONE
  } rsel_e;

  function automatic rsel_e addr_decode(input logic [31:0] a);
    if (a >= ADDR_DIP_LO && a < ADDR_DIP_HI) return RSEL_DIP_LO;
    if (a >= ADDR_DIP_HI && a < ADDR_KEY)    return RSEL_DIP_HI;
    if (a >= ADDR_KEY    && a < ADDR_END)    return RSEL_KEY;
    return RSEL_NONE;
  endfunction

endpackage

// File: rtl/user_input_reader_debounce.sv
// Per-bit 2-flop synchronizer plus 3-sample debouncer, sampled on the shared tick.
module input_debounce #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb,
  output logic [WIDTH-1:0] deb_nxt
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] hist0_q, hist0_d, hist1_q, hist1_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] agree;

  // A bit only moves when the current sample matches the previous two.
  assign agree   = ~(sync2_q ^ hist0_q) & ~(sync2_q ^ hist1_q);
  assign hist0_d = tick ? sync2_q : hist0_q;
  assign hist1_d = tick ? hist0_q : hist1_q;
  assign deb_d   = tick ? ((agree & sync2_q) | (~agree & deb_q)) : deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      hist0_q <= RST_VAL;
      hist1_q <= RST_VAL;
      deb_q   <= RST_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      deb_q   <= deb_d;
    end
  end

  assign deb     = deb_q;
  assign deb_nxt = deb_d;

endmodule

// File: rtl/user_input_reader.sv
// Memory-mapped DIP switch / push-key reader with debouncing, sticky press events and masked IRQ.
module user_input_reader
  import user_input_reader_pkg::*;
#(
  parameter logic [31:0] DEB_CNT = DEB_CNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        We,
  input  logic [31:0] ADDR,
  input  logic [31:0] In_WD,
  input  logic [63:0] dip_switch,
  input  logic [7:0]  user_key,
  output logic [31:0] In_RD,
  output logic        IRQ
);

  logic [31:0] cnt_q, cnt_d;
  logic        tick;

  assign tick  = (cnt_q == 32'd0);
  assign cnt_d = tick ? (DEB_CNT - 32'd1) : (cnt_q - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= DEB_CNT - 32'd1;
    else       cnt_q <= cnt_d;
  end

  logic [63:0] deb_dip, dip_nxt_unused;
  logic [7:0]  deb_key, deb_key_nxt;

  input_debounce #(.WIDTH(64), .RST_VAL(64'd0)) u_dip (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .raw     (dip_switch),
    .deb     (deb_dip),
    .deb_nxt (dip_nxt_unused)
  );

  // Keys idle released (high), so reset and its release never look like a press.
  input_debounce #(.WIDTH(8), .RST_VAL(8'hFF)) u_key (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .raw     (user_key),
    .deb     (deb_key),
    .deb_nxt (deb_key_nxt)
  );

  logic [7:0]  pressed, press_rise, clr;
  logic [7:0]  evt_q, evt_d, mask_q, mask_d;
  logic        key_wr;
  logic [15:0] wd_unused;

  assign pressed    = ~deb_key;
  assign press_rise = deb_key & ~deb_key_nxt;
  assign key_wr     = We && (addr_decode(ADDR) == RSEL_KEY);
  assign clr        = key_wr ? In_WD[15:8] : 8'h00;
  assign wd_unused  = {In_WD[31:24], In_WD[7:0]};

  // Set is OR'd after the clear so a same-cycle press survives W1C.
  assign evt_d  = (evt_q & ~clr) | press_rise;
  assign mask_d = key_wr ? In_WD[23:16] : mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q  <= 8'h00;
      mask_q <= 8'h00;
    end else begin
      evt_q  <= evt_d;
      mask_q <= mask_d;
    end
  end

  assign IRQ = |(evt_q & mask_q);

  always_comb begin
    In_RD = RD_UNMAPPED;
    case (addr_decode(ADDR))
      RSEL_DIP_LO: In_RD = deb_dip[31:0];
      RSEL_DIP_HI: In_RD = deb_dip[63:32];
      RSEL_KEY:    In_RD = {8'd0, mask_q, evt_q, pressed};
      default:     In_RD = RD_UNMAPPED;
    endcase
  end

endmodule
